// File: rtl/mem_responder_if.sv
// mem_responder_if: Read/Write memory handshake between the control unit and main memory.
//   master : control unit  - drives Read, Write, Addr (from MAR), DataIn (from MDR)
//   slave  : mem_responder - drives DataOut (to MDR mux), MFC, Busy, AddrErr
// Parameter DATA_W sets the data word width; Addr is always a 32-bit word address.
interface mem_responder_if #(
  parameter int unsigned DATA_W = 32
);
  logic              Read;
  logic              Write;
  logic [31:0]       Addr;
  logic [DATA_W-1:0] DataIn;
  logic [DATA_W-1:0] DataOut;
  logic              MFC;
  logic              Busy;
  logic              AddrErr;

  modport master (
    output Read, Write, Addr, DataIn,
    input  DataOut, MFC, Busy, AddrErr
  );

  modport slave (
    input  Read, Write, Addr, DataIn,
    output DataOut, MFC, Busy, AddrErr
  );
endinterface

// File: rtl/mem_responder.sv
// mem_responder: word-addressed main memory answering the control unit's Read/Write strobes.
// A request is latched in IDLE, waits WAIT_CYCLES states, commits on entry to RESP (one-cycle
// MFC pulse), then sits in HOLD until both strobes drop so a held strobe is serviced once.
//
// Ports:
//   Clock - system clock, posedge
//   Reset - synchronous, active-high; memory array contents are kept
//   bus   - mem_responder_if.slave (Read, Write, Addr, DataIn in; DataOut, MFC, Busy, AddrErr out)
//
// Parameters: ADDR_W (depth 2^ADDR_W), DATA_W, WAIT_CYCLES (0-15), PROT_LIMIT.
// Optional feature: define MEM_PROTECT_EN to reject writes below PROT_LIMIT with AddrErr=1.
module mem_responder #(
  parameter int unsigned ADDR_W      = 9,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned WAIT_CYCLES = 2,
  parameter int unsigned PROT_LIMIT  = 64
) (
  input logic            Clock,
  input logic            Reset,
  mem_responder_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StWait, StResp, StHold} state_e;

  localparam logic [3:0] WaitInit = 4'(WAIT_CYCLES);

`ifdef MEM_PROTECT_EN
  localparam bit ProtectEn = 1'b1;
`else
  localparam bit ProtectEn = 1'b0;
`endif

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              oor_q, oor_d;
  logic              rd_q, rd_d;
  logic              wr_q, wr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic              err_q, err_d;

  logic [DATA_W-1:0] mem_q [2**ADDR_W];

  logic accept, commit, prot_hit, bad, mem_we;

  assign accept = (state_q == StIdle) && (bus.Read || bus.Write);

  // State register
  always_ff @(posedge Clock) begin
    if (Reset) state_q <= StIdle;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          cnt_d   = WaitInit;
          state_d = (WaitInit == 4'd0) ? StResp : StWait;
        end
      end
      StWait: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = StResp;
      end
      StResp: state_d = StHold;
      StHold: begin
        if (!bus.Read && !bus.Write) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs
  always_comb begin
    bus.MFC     = (state_q == StResp);
    bus.Busy    = (state_q != StIdle);
    bus.DataOut = dout_q;
    bus.AddrErr = err_q;
  end

  // Request capture; the _d values double as the commit operands, which covers the
  // zero-wait case where acceptance and commit share one edge.
  always_comb begin
    addr_d  = addr_q;
    oor_d   = oor_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    wdata_d = wdata_q;
    if (accept) begin
      addr_d  = bus.Addr[ADDR_W-1:0];
      oor_d   = |bus.Addr[31:ADDR_W];
      rd_d    = bus.Read;
      wr_d    = bus.Write;
      wdata_d = bus.DataIn;
    end
  end

  assign commit   = (state_d == StResp);
  assign prot_hit = ProtectEn && wr_d && (32'(addr_d) < PROT_LIMIT);
  assign bad      = (rd_d && wr_d) || oor_d || prot_hit;
  assign mem_we   = commit && wr_d && !bad;

  always_comb begin
    dout_d = dout_q;
    err_d  = err_q;
    if (commit) begin
      err_d = bad;
      // Read/Write conflict leaves DataOut alone; out-of-range read drives zero.
      if (rd_d && !wr_d) dout_d = oor_d ? '0 : mem_q[addr_d];
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      cnt_q   <= '0;
      addr_q  <= '0;
      oor_q   <= 1'b0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      wdata_q <= '0;
      dout_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      oor_q   <= oor_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      wdata_q <= wdata_d;
      dout_q  <= dout_d;
      err_q   <= err_d;
    end
  end

  // Array has no reset; a pending write is dropped if Reset lands on its commit edge.
  always_ff @(posedge Clock) begin
    if (mem_we && !Reset) mem_q[addr_d] <= wdata_d;
  end

endmodule
